uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the transmit path's baud timing.
- Contains its own mid-bit baud timer. Oversamples the rx pin at the system clock rate and deserialises frames LSB-first.
- Presents each received byte with a one-cycle `rcv` strobe.
- Sits between the FPGA rx pin (100 MHz Nexys 4 domain) and the command/data consumer logic.

---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial pin in, byte and status strobes out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    modport master (output rx, input data, rcv, busy, frame_err, parity_err);
    modport slave  (input rx, output data, rcv, busy, frame_err, parity_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; define UART_RX_PARITY_EN for 8E1
// framing with a parity_err strobe alongside rcv.
module uart_rx #(
    parameter int unsigned M = 868
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int unsigned CW   = $clog2(M);
    localparam int unsigned HALF = M / 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    sync_q, sync_d;
    logic [7:0]    data_q, data_d;
    logic          rcv_q, rcv_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          rx_s;
    logic          tick_c;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    assign rx_s = sync_q[1];

    // Start bit is sampled at its mid-point; every later bit one full period on.
    always_comb begin
        if (state_q == S_START) tick_c = (cnt_q == CW'(HALF - 1));
        else                    tick_c = (cnt_q == CW'(M - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            sync_q  <= 2'b11;
            data_q  <= '0;
            rcv_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            rcv_q   <= rcv_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: if (tick_c) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (tick_c && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_STOP;
`endif
                end
            end
            S_PAR:   if (tick_c) state_d = S_STOP;
            S_STOP:  if (tick_c) state_d = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sync_d  = {sync_q[0], bus.rx};
        cnt_d   = '0;
        shift_d = shift_q;
        bit_d   = bit_q;
        data_d  = data_q;
        rcv_d   = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_START: begin
                cnt_d = tick_c ? '0 : cnt_q + CW'(1);
                if (tick_c && !rx_s) bit_d = 3'd0;
            end
            S_DATA: begin
                cnt_d = tick_c ? '0 : cnt_q + CW'(1);
                if (tick_c) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end
            end
            S_PAR: begin
                cnt_d = tick_c ? '0 : cnt_q + CW'(1);
`ifdef UART_RX_PARITY_EN
                if (tick_c) par_d = rx_s;
`endif
            end
            S_STOP: begin
                cnt_d = tick_c ? '0 : cnt_q + CW'(1);
                // A low stop bit keeps the old byte and only flags the framing error.
                if (tick_c) begin
                    if (rx_s) begin
                        data_d = shift_q;
                        rcv_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d = par_q ^ (^shift_q);
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign bus.data      = data_q;
    assign bus.rcv       = rcv_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at M=16; define UART_RX_PARITY_EN to cover 8E1.
module tb_uart_rx;
    localparam int unsigned M  = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned RCV_LAT = 2 + M / 2 + (NB - 1) * M + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_if bus ();
    uart_rx #(.M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rcv_n   = 0;
    int ferr_n  = 0;
    int perr_n  = 0;
    int perr_rcv_n = 0;
    int last_rcv_cyc = 0;
    int prev_rcv_cyc = 0;
    logic [7:0] rcv_log[$];
    int fall, base, fbase, pbase;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.rcv) begin
            rcv_n++;
            prev_rcv_cyc = last_rcv_cyc;
            last_rcv_cyc = cyc;
            rcv_log.push_back(bus.data);
            if (bus.parity_err) perr_rcv_n++;
        end
        if (bus.frame_err)  ferr_n++;
        if (bus.parity_err) perr_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        step(M);
    endtask

    task automatic send_data(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_data(d);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        bus.rx = 1'b1;
        step(3);
        chk("rst_data", 32'(bus.data), 32'h0);
        chk("rst_rcv", 32'(bus.rcv), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ferr", 32'(bus.frame_err), 32'h0);
        chk("rst_perr", 32'(bus.parity_err), 32'h0);
        rst = 1'b0;
        step(5);

        // Single frame 0xA5 and its latency from the pin edge.
        base = rcv_n;
        fall = cyc;
        send_frame(8'hA5, 1'b1);
        step(2);
        chk("a5_count", 32'(rcv_n - base), 32'd1);
        chk("a5_latency", 32'(last_rcv_cyc - fall), 32'(RCV_LAT));
        chk("a5_data", 32'(bus.data), 32'hA5);
        chk("a5_ferr", 32'(ferr_n), 32'd0);
        chk("a5_busy", 32'(bus.busy), 32'h0);

        // Back-to-back 0x00 then 0xFF, no idle gap.
        base = rcv_n;
        rcv_log.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        step(2);
        chk("b2b_count", 32'(rcv_n - base), 32'd2);
        chk("b2b_spacing", 32'(last_rcv_cyc - prev_rcv_cyc), 32'(NB * M));
        chk("b2b_size", 32'(rcv_log.size()), 32'd2);
        if (rcv_log.size() == 2) begin
            chk("b2b_first", 32'(rcv_log[0]), 32'h00);
            chk("b2b_second", 32'(rcv_log[1]), 32'hFF);
        end
        chk("b2b_data", 32'(bus.data), 32'hFF);

        // Five-cycle low glitch is a false start.
        base = rcv_n;
        bus.rx = 1'b0;
        step(5);
        chk("glitch_busy_hi", 32'(bus.busy), 32'h1);
        bus.rx = 1'b1;
        step(20);
        chk("glitch_busy_lo", 32'(bus.busy), 32'h0);
        chk("glitch_rcv", 32'(rcv_n - base), 32'd0);
        chk("glitch_ferr", 32'(ferr_n), 32'd0);

        // 0x3C with low stop bit, line held low, then recovery with 0x12.
        base  = rcv_n;
        fbase = ferr_n;
        send_data(8'h3C);
`ifdef UART_RX_PARITY_EN
        drive_bit(1'b0);
`endif
        bus.rx = 1'b0;
        step(M + 40);
        chk("brk_busy_hi", 32'(bus.busy), 32'h1);
        chk("brk_ferr", 32'(ferr_n - fbase), 32'd1);
        bus.rx = 1'b1;
        step(5);
        chk("brk_busy_lo", 32'(bus.busy), 32'h0);
        chk("brk_data_kept", 32'(bus.data), 32'hFF);
        chk("brk_no_rcv", 32'(rcv_n - base), 32'd0);
        send_frame(8'h12, 1'b1);
        step(2);
        chk("rec_data", 32'(bus.data), 32'h12);
        chk("rec_count", 32'(rcv_n - base), 32'd1);
        chk("rec_ferr", 32'(ferr_n - fbase), 32'd1);

        // Reset during bit 4 of 0x55, then 0x81.
        base  = rcv_n;
        fbase = ferr_n;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        bus.rx = 1'b1;
        step(8);
        chk("mid_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", 32'(bus.data), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        step(2);
        rst = 1'b0;
        step(20);
        chk("mid_no_rcv", 32'(rcv_n - base), 32'd0);
        chk("mid_no_ferr", 32'(ferr_n - fbase), 32'd0);
        send_frame(8'h81, 1'b1);
        step(2);
        chk("post_rst_count", 32'(rcv_n - base), 32'd1);
        chk("post_rst_data", 32'(bus.data), 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x07 with correct parity bit 1, then with wrong parity bit 0.
        base  = rcv_n;
        pbase = perr_n;
        send_data(8'h07);
        drive_bit(1'b1);
        drive_bit(1'b1);
        step(2);
        chk("par_ok_count", 32'(rcv_n - base), 32'd1);
        chk("par_ok_data", 32'(bus.data), 32'h07);
        chk("par_ok_perr", 32'(perr_n - pbase), 32'd0);
        base  = rcv_n;
        pbase = perr_rcv_n;
        send_data(8'h07);
        drive_bit(1'b0);
        drive_bit(1'b1);
        step(2);
        chk("par_bad_count", 32'(rcv_n - base), 32'd1);
        chk("par_bad_with_rcv", 32'(perr_rcv_n - pbase), 32'd1);
        chk("par_bad_data", 32'(bus.data), 32'h07);
`else
        pbase = 0;
        chk("no_parity_err", 32'(perr_n), 32'(pbase));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
